sha256_bus_master: RTL
======================

# sha256_bus_master

Bus initiator that drives the SHA-256 core's register interface to hash one 512-bit block per request. It takes a block, a first/next flag and a mode from a local client. It then issues the word-level cs/we/address bus cycles: load the block, start the core, poll status, read back the digest. The 256-bit digest is returned to the client. It sits between the HSM's message-scheduling logic and the register-mapped SHA-256 core, and no software is involved.

## Interface
- SETTLE_CYCLES, default 4: idle cycles between the CTRL write and the first STATUS poll. Covers the core's ready-flag propagation lag. Legal range is 4..15.
- POLL_TIMEOUT, default 255: maximum number of STATUS polls before the block aborts.
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- first  in  1  1 = init (first block of a message), 0 = next (continuation block)
- mode  in  1  1 = SHA-256, 0 = SHA-224
- block  in  512  message block; bits [511:480] are word 0
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- digest  out  256  last digest read; bits [255:224] come from DIGEST0
- digest_valid  out  1  one-cycle pulse when digest has been updated
- err  out  1  one-cycle pulse on abort (bus error or poll timeout)
- cs  out  1  bus select
- we  out  1  bus write
- address  out  8  bus address
- write_data  out  32  bus write data
- read_data  in  32  bus read data; combinational, valid in the same cycle as cs=1, we=0
- error  in  1  bus error; sampled in every cycle where cs=1

## Operation
- Register map of the target:
  - CTRL 0x08: init bit 0, next bit 1, mode bit 2.
  - STATUS 0x09: ready bit 0, valid bit 1.
  - BLOCK0..15 0x10..0x1F.
  - DIGEST0..7 0x20..0x27.
- Every bus cycle lasts exactly one clk with cs=1. There are no wait states.
- On accepted start, the block latches block, first and mode into internal registers. Later changes on the client inputs are ignored.
- State machine:
  - IDLE: cs=0. On start, go to WBLK with word index i=0.
  - WBLK: cs=1, we=1, address=0x10+i, write_data=block word i. When i=15, go to WCTRL; otherwise increment i.
  - WCTRL: cs=1, we=1, address=0x08, write_data={29'h0, mode, ~first, first}. Go to SETTLE with the counter cleared.
  - SETTLE: cs=0 for SETTLE_CYCLES cycles, then go to POLL.
  - POLL: cs=1, we=0, address=0x09.
    - If read_data[0]=1, go to RDIG with j=0.
    - Otherwise increment the poll count. When the count reaches POLL_TIMEOUT, go to ABORT.
  - RDIG: cs=1, we=0, address=0x20+j. Capture read_data into digest word j. When j=7, go to DONE.
  - DONE: cs=0, pulse digest_valid, go to IDLE.
  - ABORT: cs=0, pulse err, go to IDLE. The digest register keeps its prior value.
- Any cycle with cs=1 and error=1 goes to ABORT next cycle, whatever the state.
- In SHA-224 mode all 8 digest words are still read. Word 7 carries no meaning and is passed through unmodified.
- When cs=0: we=0, address=0, write_data=0.
- When cs=1 and we=0: write_data=0.

## Timing
- Reset values:
  - Outputs: busy=0, digest=0, digest_valid=0, err=0, cs=0, we=0, address=0, write_data=0.
  - State: IDLE, all counters 0.
- Reset asserted mid-operation returns the block to reset values immediately. No partial bus cycle is completed.
- Cycle sequence, with start sampled at cycle 0:
  - Cycles 1..16: BLOCK writes.
  - Cycle 17: CTRL write.
  - Cycles 18..17+SETTLE_CYCLES: SETTLE.
  - Cycles from 18+SETTLE_CYCLES: first POLL.
  - Next 8 cycles after the first poll that returns ready=1: digest reads.
  - Following cycle: digest_valid.
- Minimum latency from start to digest_valid is 27+SETTLE_CYCLES plus the extra poll cycles.
- digest updates on the same edge that raises digest_valid. It is stable until the next DONE.
- busy falls in the cycle after DONE or ABORT. That is the first cycle in which a new start is accepted.
- start while busy=1 is ignored and not queued.
- The poll counter is 8 bits wide and does not wrap. Timeout occurs after exactly POLL_TIMEOUT not-ready reads.

## Test plan
- "abc" test, SHA-256:
  - Stimulus: padded block 61626380_00000000…00000018 with first=1, mode=1, against the SHA-256 core.
  - Required: digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with one digest_valid pulse.
- Same block, SHA-224: first=1, mode=0 -> digest words 0..6 = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
- Bus trace:
  - Stimulus: any start.
  - Required: addresses 0x10..0x1F in cycles 1..16, 0x08 with write_data=0x5 in cycle 17 (first=1, mode=1), then cs=0 for 4 cycles, then polls at 0x09.
- Bus error: error=1 forced on the 5th BLOCK write -> err pulse the next cycle, busy=0 one cycle later, digest unchanged, no further cs.
- Poll timeout:
  - Stimulus: stub target that holds STATUS=0, with POLL_TIMEOUT=10.
  - Required: exactly 10 poll cycles, then an err pulse.
- Overlap and reset:
  - Stimulus: start pulsed while busy; then reset_n asserted during RDIG.
  - Required: the second start is ignored. All outputs return to 0 asynchronously, and the next start runs a full correct hash.

Source files
------------

// File: rtl/sha256_bus_master.sv
// Bus initiator for the register-mapped SHA-256 core: loads one block,
// starts the core, polls for ready and reads the digest back.
module sha256_bus_master #(
    parameter int SETTLE_CYCLES = 4,
    parameter int POLL_TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         first,
    input  logic         mode,
    input  logic [511:0] block,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         err,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data,
    input  logic         error
);

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_BLOCK  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST = 8'h20;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] POLL_LAST   = 8'(POLL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WBLK, WCTRL, SETTLE, POLL, RDIG, DONE, ABORT
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [511:0] blk_q;
    logic         first_q, mode_q;
    logic [223:0] dig_sh_q;
    logic         load, shift_blk, capture, commit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Words 0..6 collect in a shadow so an abort mid-readback leaves digest intact
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q    <= '0;
            first_q  <= 1'b0;
            mode_q   <= 1'b0;
            dig_sh_q <= '0;
            digest   <= '0;
        end else begin
            if (load) begin
                blk_q   <= block;
                first_q <= first;
                mode_q  <= mode;
            end else if (shift_blk) begin
                blk_q <= {blk_q[479:0], 32'h0};
            end
            if (capture) dig_sh_q <= {dig_sh_q[191:0], read_data};
            if (commit)  digest   <= {dig_sh_q, read_data};
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cs           = 1'b0;
        we           = 1'b0;
        address      = '0;
        write_data   = '0;
        busy         = (state_q != IDLE);
        digest_valid = (state_q == DONE);
        err          = (state_q == ABORT);
        load         = 1'b0;
        shift_blk    = 1'b0;
        capture      = 1'b0;
        commit       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WBLK;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            WBLK: begin
                cs         = 1'b1;
                we         = 1'b1;
                address    = ADDR_BLOCK | {4'h0, cnt_q[3:0]};
                write_data = blk_q[511:480];
                shift_blk  = 1'b1;
                if (cnt_q[3:0] == 4'hF) begin
                    state_d = WCTRL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WCTRL: begin
                cs         = 1'b1;
                we         = 1'b1;
                address    = ADDR_CTRL;
                write_data = {29'h0, mode_q, ~first_q, first_q};
                state_d    = SETTLE;
                cnt_d      = '0;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = POLL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            POLL: begin
                cs      = 1'b1;
                address = ADDR_STATUS;
                if (read_data[0]) begin
                    state_d = RDIG;
                    cnt_d   = '0;
                end else if (cnt_q == POLL_LAST) begin
                    state_d = ABORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RDIG: begin
                cs      = 1'b1;
                address = ADDR_DIGEST | {5'h0, cnt_q[2:0]};
                capture = 1'b1;
                if (cnt_q[2:0] == 3'd7) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE, ABORT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // A bus error overrides whatever the current beat would have done
        if (cs && error) begin
            state_d   = ABORT;
            cnt_d     = '0;
            capture   = 1'b0;
            commit    = 1'b0;
            shift_blk = 1'b0;
        end
    end

endmodule
